// File: rtl/blake_round_counter.sv
// rtl/blake_round_counter.sv - BLAKE-512 round/step sequencer for the 2-G-core datapath
//
// Generates the round index, the sigma row select (round mod 10) and the
// G-pair step select that steer message/constant muxing and column/diagonal
// routing. Works opposite blake_controller: it consumes init_round and
// round_ing, and returns count_done.
//
// Optional feature macro: BLAKE_ROUND_STALL_EN (adds the stall input).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   init_round  in   start/clear request; restarts from round 0 step 0
//   round_ing   in   controller running; advance enable
//   stall       in   (BLAKE_ROUND_STALL_EN only) datapath back-pressure, freezes all state
//   count_done  out  all rounds complete; registered level
//   round_idx   out  current round, 0..NUM_ROUNDS-1
//   sigma_idx   out  sigma row select, round_idx mod 10
//   g_step      out  G-pair select, 0..STEPS_PER_ROUND-1
//   diag        out  diagonal half of the round (g_step >= 2)
//   last_step   out  combinational; final step of the final round

module blake_round_counter #(
   parameter int NUM_ROUNDS      = 16,
   parameter int STEPS_PER_ROUND = 4,
   parameter int RW              = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init_round,
   input  logic          round_ing,
`ifdef BLAKE_ROUND_STALL_EN
   input  logic          stall,
`endif
   output logic          count_done,
   output logic [RW-1:0] round_idx,
   output logic [3:0]    sigma_idx,
   output logic [1:0]    g_step,
   output logic          diag,
   output logic          last_step
);

   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);
   localparam logic [1:0]    LAST_G     = 2'(STEPS_PER_ROUND - 1);
   localparam logic [3:0]    LAST_SIGMA = 4'd9;

   logic step_wrap;
   logic flow_ok;
   logic advance;

   assign step_wrap = (g_step == LAST_G);
   assign last_step = step_wrap && (round_idx == LAST_ROUND);

   // Steps 2 and 3 cover the diagonal G functions.
   assign diag = g_step[1];

`ifdef BLAKE_ROUND_STALL_EN
   assign flow_ok = ~stall;
`else
   assign flow_ok = 1'b1;
`endif

   // Once done, the counters park on their final values until init/reset.
   assign advance = round_ing & ~init_round & ~count_done & flow_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_idx  <= '0;
         sigma_idx  <= '0;
         g_step     <= '0;
         count_done <= 1'b0;
      end else if (init_round) begin
         round_idx  <= '0;
         sigma_idx  <= '0;
         g_step     <= '0;
         count_done <= 1'b0;
      end else if (advance) begin
         if (last_step) begin
            count_done <= 1'b1;
         end else if (step_wrap) begin
            g_step    <= '0;
            round_idx <= round_idx + 1'b1;
            // Independent wrapping counter avoids a mod-10 divider.
            sigma_idx <= (sigma_idx == LAST_SIGMA) ? 4'd0 : sigma_idx + 4'd1;
         end else begin
            g_step <= g_step + 2'd1;
         end
      end
   end

endmodule
